ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module  : ex_mem_stage
// Purpose : EX-stage ALU and branch unit, followed by the EX/MEM pipeline register.
//           Optional macro MULT_EN adds a stalling shift-add multiplier (ALUCtrl 00111).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Control,
   input  logic [4:0]  ALUCtrl,
   input  logic        Sign,
   input  logic [31:0] Data1_in,
   input  logic [31:0] Data2_in,
   input  logic [31:0] Imm32_in,
   input  logic [31:0] PC_in,
   input  logic [4:0]  Shamt_in,
   input  logic [4:0]  Rt_in,
   input  logic [4:0]  Rd_in,
   input  logic        ALUSrc1_in,
   input  logic        ALUSrc2_in,
   input  logic        Branch_in,
   input  logic        RegWrite_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        LbuOp_in,
   input  logic [1:0]  RegDst_in,
   input  logic [1:0]  MemtoReg_in,
   output logic [31:0] ALUOut_out,
   output logic [31:0] Data2_out,
   output logic [31:0] PC_out,
   output logic [4:0]  WriteReg_out,
   output logic        RegWrite_out,
   output logic        MemRead_out,
   output logic        MemWrite_out,
   output logic        LbuOp_out,
   output logic [1:0]  MemtoReg_out,
   output logic        BranchTaken,
   output logic [31:0] BranchTarget,
   output logic        Stall_out
);

   localparam logic [4:0] c_op_add = 5'b00000;
   localparam logic [4:0] c_op_sub = 5'b00001;
   localparam logic [4:0] c_op_and = 5'b00010;
   localparam logic [4:0] c_op_or  = 5'b00011;
   localparam logic [4:0] c_op_xor = 5'b00100;
   localparam logic [4:0] c_op_nor = 5'b00101;
   localparam logic [4:0] c_op_slt = 5'b00110;
   localparam logic [4:0] c_op_sll = 5'b01000;
   localparam logic [4:0] c_op_srl = 5'b01001;
   localparam logic [4:0] c_op_sra = 5'b01010;
   localparam logic [4:0] c_br_eq  = 5'b10000;
   localparam logic [4:0] c_br_ne  = 5'b10001;
   localparam logic [4:0] c_br_lez = 5'b10010;
   localparam logic [4:0] c_br_gtz = 5'b10011;
   localparam logic [4:0] c_br_ltz = 5'b10100;

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        slt_bit;
   logic [31:0] alu_res;
   logic        br_cond;
   logic [4:0]  write_reg;
   logic        mul_stall;
   logic        flush;
   logic        hold;

   assign flush = Control[1];
   assign hold  = (Control == 2'b01);

   always_comb begin
      op_a = ALUSrc1_in ? {27'd0, Shamt_in} : Data1_in;
      op_b = ALUSrc2_in ? Imm32_in : Data2_in;
   end

   assign slt_bit = Sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);

`ifdef MULT_EN
   localparam logic [4:0] c_op_mul = 5'b00111;
   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_busy = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   logic [1:0]  mstate_q, mstate_d;
   logic [4:0]  mcount_q, mcount_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] prod_q, prod_d;
   logic        is_mul;

   assign is_mul = (ALUCtrl == c_op_mul);

   // Stall covers the accepting IDLE cycle plus all 32 BUSY cycles; a flush drops it at once.
   assign mul_stall = !flush &&
                      ((mstate_q == c_st_busy) ||
                       ((mstate_q == c_st_idle) && is_mul && (Control == 2'b00)));

   always_comb begin
      mstate_d = mstate_q;
      mcount_d = mcount_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      if (flush) begin
         mstate_d = c_st_idle;
      end else if (!hold) begin
         case (mstate_q)
            c_st_idle: begin
               if (is_mul) begin
                  mcand_d  = op_a;
                  mplier_d = op_b;
                  prod_d   = 32'd0;
                  mcount_d = 5'd0;
                  mstate_d = c_st_busy;
               end
            end
            c_st_busy: begin
               if (mplier_q[0]) begin
                  prod_d = prod_q + mcand_q;
               end
               mcand_d  = {mcand_q[30:0], 1'b0};
               mplier_d = {1'b0, mplier_q[31:1]};
               mcount_d = mcount_q + 5'd1;
               if (mcount_q == 5'd31) begin
                  mstate_d = c_st_done;
               end
            end
            c_st_done: begin
               mstate_d = c_st_idle;
            end
            default: begin
               mstate_d = c_st_idle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mstate_q <= c_st_idle;
         mcount_q <= 5'd0;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         prod_q   <= 32'd0;
      end else begin
         mstate_q <= mstate_d;
         mcount_q <= mcount_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end
`else
   assign mul_stall = 1'b0;
`endif

   always_comb begin
      alu_res = 32'd0;
      case (ALUCtrl)
         c_op_add: alu_res = op_a + op_b;
         c_op_sub: alu_res = op_a - op_b;
         c_op_and: alu_res = op_a & op_b;
         c_op_or:  alu_res = op_a | op_b;
         c_op_xor: alu_res = op_a ^ op_b;
         c_op_nor: alu_res = ~(op_a | op_b);
         c_op_slt: alu_res = {31'd0, slt_bit};
         c_op_sll: alu_res = op_b << op_a[4:0];
         c_op_srl: alu_res = op_b >> op_a[4:0];
         c_op_sra: alu_res = $signed(op_b) >>> op_a[4:0];
`ifdef MULT_EN
         // Only reaches the register in DONE, when the product is complete.
         c_op_mul: alu_res = prod_q;
`endif
         default:  alu_res = 32'd0;
      endcase
   end

   always_comb begin
      br_cond = 1'b0;
      case (ALUCtrl)
         c_br_eq:  br_cond = (op_a == op_b);
         c_br_ne:  br_cond = (op_a != op_b);
         c_br_lez: br_cond = op_a[31] || (op_a == 32'd0);
         c_br_gtz: br_cond = !op_a[31] && (op_a != 32'd0);
         c_br_ltz: br_cond = op_a[31];
         default:  br_cond = 1'b0;
      endcase
   end

   assign BranchTaken  = reset && !flush && Branch_in && br_cond;
   assign BranchTarget = PC_in + {Imm32_in[29:0], 2'b00};
   assign Stall_out    = reset && mul_stall;

   always_comb begin
      case (RegDst_in)
         2'b01:   write_reg = Rd_in;
         2'b10:   write_reg = 5'd31;
         default: write_reg = Rt_in;
      endcase
   end

   logic [31:0] alu_out_q, alu_out_d;
   logic [31:0] data2_q, data2_d;
   logic [31:0] pc_q, pc_d;
   logic [4:0]  write_reg_q, write_reg_d;
   logic        reg_write_q, reg_write_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic        lbu_op_q, lbu_op_d;
   logic [1:0]  mem_to_reg_q, mem_to_reg_d;

   // Priority: flush, then hold, then stall bubble, then normal update.
   always_comb begin
      alu_out_d    = alu_out_q;
      data2_d      = data2_q;
      pc_d         = pc_q;
      write_reg_d  = write_reg_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      lbu_op_d     = lbu_op_q;
      mem_to_reg_d = mem_to_reg_q;
      if (flush || (!hold && mul_stall)) begin
         alu_out_d    = 32'd0;
         data2_d      = 32'd0;
         pc_d         = 32'd0;
         write_reg_d  = 5'd0;
         reg_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         lbu_op_d     = 1'b0;
         mem_to_reg_d = 2'b00;
      end else if (!hold) begin
         alu_out_d    = alu_res;
         data2_d      = Data2_in;
         pc_d         = PC_in;
         write_reg_d  = write_reg;
         reg_write_d  = RegWrite_in;
         mem_read_d   = MemRead_in;
         mem_write_d  = MemWrite_in;
         lbu_op_d     = LbuOp_in;
         mem_to_reg_d = MemtoReg_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_out_q    <= 32'd0;
         data2_q      <= 32'd0;
         pc_q         <= 32'd0;
         write_reg_q  <= 5'd0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         lbu_op_q     <= 1'b0;
         mem_to_reg_q <= 2'b00;
      end else begin
         alu_out_q    <= alu_out_d;
         data2_q      <= data2_d;
         pc_q         <= pc_d;
         write_reg_q  <= write_reg_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         lbu_op_q     <= lbu_op_d;
         mem_to_reg_q <= mem_to_reg_d;
      end
   end

   assign ALUOut_out   = alu_out_q;
   assign Data2_out    = data2_q;
   assign PC_out       = pc_q;
   assign WriteReg_out = write_reg_q;
   assign RegWrite_out = reg_write_q;
   assign MemRead_out  = mem_read_q;
   assign MemWrite_out = mem_write_q;
   assign LbuOp_out    = lbu_op_q;
   assign MemtoReg_out = mem_to_reg_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module  : tb_ex_mem_stage
// Purpose : Scoreboard bench for ex_mem_stage (MULT_EN paths included when defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  Control;
   logic [4:0]  ALUCtrl;
   logic        Sign;
   logic [31:0] Data1_in, Data2_in, Imm32_in, PC_in;
   logic [4:0]  Shamt_in, Rt_in, Rd_in;
   logic        ALUSrc1_in, ALUSrc2_in, Branch_in;
   logic        RegWrite_in, MemRead_in, MemWrite_in, LbuOp_in;
   logic [1:0]  RegDst_in, MemtoReg_in;
   logic [31:0] ALUOut_out, Data2_out, PC_out;
   logic [4:0]  WriteReg_out;
   logic        RegWrite_out, MemRead_out, MemWrite_out, LbuOp_out;
   logic [1:0]  MemtoReg_out;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Stall_out;

   ex_mem_stage dut (
      .clk(clk), .reset(reset), .Control(Control), .ALUCtrl(ALUCtrl), .Sign(Sign),
      .Data1_in(Data1_in), .Data2_in(Data2_in), .Imm32_in(Imm32_in), .PC_in(PC_in),
      .Shamt_in(Shamt_in), .Rt_in(Rt_in), .Rd_in(Rd_in),
      .ALUSrc1_in(ALUSrc1_in), .ALUSrc2_in(ALUSrc2_in), .Branch_in(Branch_in),
      .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .LbuOp_in(LbuOp_in), .RegDst_in(RegDst_in), .MemtoReg_in(MemtoReg_in),
      .ALUOut_out(ALUOut_out), .Data2_out(Data2_out), .PC_out(PC_out),
      .WriteReg_out(WriteReg_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
      .MemWrite_out(MemWrite_out), .LbuOp_out(LbuOp_out), .MemtoReg_out(MemtoReg_out),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Stall_out(Stall_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] alu;
      logic [31:0] d2;
      logic [31:0] pc;
      logic [4:0]  wr;
      logic [5:0]  ctl;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_alu(input logic [4:0] op, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = 32'd0;
      case (op)
         5'd0:  r = a + b;
         5'd1:  r = a + (~b + 32'd1);
         5'd2:  r = a & b;
         5'd3:  r = a | b;
         5'd4:  r = a ^ b;
         5'd5:  r = ~a & ~b;
         5'd6:  r = sgn ? {31'd0, ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000))}
                        : {31'd0, (a < b)};
         5'd8:  r = b << a[4:0];
         5'd9:  r = b >> a[4:0];
         5'd10: begin
            r = b;
            for (int k = 0; k < 32; k++) if (k < int'(a[4:0])) r = {r[31], r[31:1]};
         end
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic exp_t model_update();
      exp_t        e;
      logic [31:0] a, b;
      a = ALUSrc1_in ? {27'd0, Shamt_in} : Data1_in;
      b = ALUSrc2_in ? Imm32_in : Data2_in;
      e.tag = "";
      e.alu = m_alu(ALUCtrl, Sign, a, b);
      e.d2  = Data2_in;
      e.pc  = PC_in;
      case (RegDst_in)
         2'b01:   e.wr = Rd_in;
         2'b10:   e.wr = 5'd31;
         default: e.wr = Rt_in;
      endcase
      e.ctl = {RegWrite_in, MemRead_in, MemWrite_in, LbuOp_in, MemtoReg_in};
      return e;
   endfunction

   function automatic exp_t zero_exp();
      exp_t e;
      e.tag = ""; e.alu = 32'd0; e.d2 = 32'd0; e.pc = 32'd0; e.wr = 5'd0; e.ctl = 6'd0;
      return e;
   endfunction

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check({e.tag, ".alu"}, ALUOut_out, e.alu);
      check({e.tag, ".d2"},  Data2_out, e.d2);
      check({e.tag, ".pc"},  PC_out, e.pc);
      check({e.tag, ".wr"},  {27'd0, WriteReg_out}, {27'd0, e.wr});
      check({e.tag, ".ctl"}, {26'd0, RegWrite_out, MemRead_out, MemWrite_out, LbuOp_out,
                              MemtoReg_out}, {26'd0, e.ctl});
      check({e.tag, ".stall"}, {31'd0, Stall_out}, 32'd0);
   endtask

   // Push the expected register contents for the current inputs, clock once, compare.
   task automatic issue(input string tag);
      exp_t e;
      if (Control[1])           e = zero_exp();
      else if (Control == 2'b01) e = last;
      else                       e = model_update();
      e.tag = tag;
      sb.push_back(e);
      last = e;
      @(posedge clk); #1;
      pop_check();
   endtask

   task automatic set_op(input logic [4:0] op, input logic sgn,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic src1, input logic [4:0] sh,
                         input logic src2, input logic [31:0] imm);
      Control = 2'b00; ALUCtrl = op; Sign = sgn;
      Data1_in = d1; Data2_in = d2; ALUSrc1_in = src1; Shamt_in = sh;
      ALUSrc2_in = src2; Imm32_in = imm;
   endtask

`ifdef MULT_EN
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv);
      int cnt;
      cnt = 0;
      set_op(5'b00111, 1'b0, a, b, 1'b0, 5'd0, 1'b0, 32'd0);
      Branch_in = 1'b0; RegDst_in = 2'b01; Rd_in = 5'd9; Rt_in = 5'd2;
      RegWrite_in = 1'b1; MemRead_in = 1'b0; MemWrite_in = 1'b0; LbuOp_in = 1'b0;
      MemtoReg_in = 2'b00; PC_in = 32'h0000_0200;
      #1;
      while (Stall_out === 1'b1 && cnt < 40) begin
         cnt++;
         @(posedge clk); #1;
         check({tag, ".bubble_alu"}, ALUOut_out, 32'd0);
         check({tag, ".bubble_rw"}, {31'd0, RegWrite_out}, 32'd0);
      end
      check({tag, ".stall_cycles"}, 32'(cnt), 32'd33);
      @(posedge clk); #1;
      check({tag, ".product"}, ALUOut_out, expv);
      check({tag, ".wr"}, {27'd0, WriteReg_out}, 32'd9);
      check({tag, ".rw"}, {31'd0, RegWrite_out}, 32'd1);
      last.alu = expv; last.d2 = b; last.pc = 32'h0000_0200; last.wr = 5'd9;
      last.ctl = 6'b100000;
      ALUCtrl = 5'b00000;
      #1;
      check({tag, ".idle_after"}, {31'd0, Stall_out}, 32'd0);
   endtask
`endif

   int          ops[11] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 15};
   logic [4:0]  br_op[10]  = '{5'b10000, 5'b10001, 5'b10001, 5'b10010, 5'b10010,
                               5'b10011, 5'b10011, 5'b10100, 5'b10100, 5'b10000};
   logic [31:0] br_a[10]   = '{32'd7, 32'd7, 32'd7, 32'd0, 32'd1,
                               32'h8000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd7};
   logic [31:0] br_b[10]   = '{32'd7, 32'd7, 32'd8, 32'd9, 32'd0,
                               32'd0, 32'd0, 32'd0, 32'd0, 32'd7};
   logic        br_en[10]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic        br_exp[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      reset = 1'b0;
      set_op(5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
      PC_in = 32'd0; Rt_in = 5'd0; Rd_in = 5'd0; Branch_in = 1'b0;
      RegWrite_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; LbuOp_in = 1'b0;
      RegDst_in = 2'b00; MemtoReg_in = 2'b00;
      last = zero_exp();
      #2;
      check("rst.alu", ALUOut_out, 32'd0);
      check("rst.wr", {27'd0, WriteReg_out}, 32'd0);
      check("rst.rw", {31'd0, RegWrite_out}, 32'd0);
      check("rst.stall", {31'd0, Stall_out}, 32'd0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      // ADD wraps to zero, destination from Rd
      set_op(5'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 1'b0, 32'd0);
      RegDst_in = 2'b01; Rd_in = 5'd5; Rt_in = 5'd3; RegWrite_in = 1'b1;
      MemtoReg_in = 2'b10; PC_in = 32'h0000_0044;
      issue("add_wrap");
      check("add_wrap.const", ALUOut_out, 32'h0000_0000);
      check("add_wrap.rd", {27'd0, WriteReg_out}, 32'd5);

      set_op(5'd6, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 1'b0, 32'd0);
      issue("slt_signed");
      check("slt_signed.const", ALUOut_out, 32'd1);
      Sign = 1'b0;
      issue("slt_unsigned");
      check("slt_unsigned.const", ALUOut_out, 32'd0);

      set_op(5'd10, 1'b0, 32'd0, 32'h8000_0000, 1'b1, 5'd4, 1'b0, 32'd0);
      issue("sra");
      check("sra.const", ALUOut_out, 32'hF800_0000);

      for (int r = 0; r < 4; r++) begin
         RegDst_in = 2'(r); Rt_in = 5'd12; Rd_in = 5'd20;
         issue($sformatf("regdst%0d", r));
      end

      for (int i = 0; i < 22; i++) begin
         set_op(5'(ops[i % 11]), 1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), $urandom);
         PC_in = $urandom; Rt_in = 5'($urandom_range(0, 31)); Rd_in = 5'($urandom_range(0, 31));
         RegDst_in = 2'($urandom_range(0, 3)); MemtoReg_in = 2'($urandom_range(0, 3));
         {RegWrite_in, MemRead_in, MemWrite_in, LbuOp_in} = 4'($urandom_range(0, 15));
         issue($sformatf("rand%0d_op%0d", i, ops[i % 11]));
      end

`ifndef MULT_EN
      set_op(5'b00111, 1'b0, 32'd6, 32'd7, 1'b0, 5'd0, 1'b0, 32'd0);
      #1;
      check("mul_off.stall", {31'd0, Stall_out}, 32'd0);
      issue("mul_off");
`endif

      // Hold keeps the last registered values; flush clears them
      set_op(5'd0, 1'b0, 32'd100, 32'd23, 1'b0, 5'd0, 1'b0, 32'd0);
      RegWrite_in = 1'b1; RegDst_in = 2'b01; Rd_in = 5'd7; PC_in = 32'h1234;
      issue("pre_hold");
      Data1_in = 32'd5; Rd_in = 5'd8; PC_in = 32'h9999; Control = 2'b01;
      issue("hold");
      Control = 2'b10;
      issue("flush10");
      Control = 2'b00;
      issue("post_flush");
      Control = 2'b11;
      issue("flush11");

      for (int j = 0; j < 10; j++) begin
         set_op(br_op[j], 1'b0, br_a[j], br_b[j], 1'b0, 5'd0, 1'b0,
                (j == 0) ? 32'hFFFF_FFFE : $urandom);
         Branch_in = br_en[j];
         PC_in = (j == 0) ? 32'h0000_0100 : $urandom;
         #1;
         check($sformatf("br%0d.taken", j), {31'd0, BranchTaken}, {31'd0, br_exp[j]});
         check($sformatf("br%0d.target", j), BranchTarget, PC_in + Imm32_in * 32'd4);
         if (j == 0) begin
            check("beq.target_const", BranchTarget, 32'h0000_00F8);
            Control = 2'b10;
            #1;
            check("beq_flush.taken", {31'd0, BranchTaken}, 32'd0);
         end
         issue($sformatf("br%0d", j));
      end
      Branch_in = 1'b0;

      // Asynchronous reset between edges after a nonzero register load
      set_op(5'd3, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 5'd0, 1'b0, 32'd0);
      RegWrite_in = 1'b1; RegDst_in = 2'b10; PC_in = 32'h40;
      issue("pre_areset");
      #2 reset = 1'b0;
      #1;
      check("areset.alu", ALUOut_out, 32'd0);
      check("areset.pc", PC_out, 32'd0);
      check("areset.wr", {27'd0, WriteReg_out}, 32'd0);
      #1 reset = 1'b1;
      last = zero_exp();
      issue("post_areset");

`ifdef MULT_EN
      run_mul("mul6x7", 32'd6, 32'd7, 32'd42);

      // Flush during BUSY cycle 10 aborts the sequence
      set_op(5'b00111, 1'b0, 32'd3, 32'd5, 1'b0, 5'd0, 1'b0, 32'd0);
      repeat (10) begin @(posedge clk); #1; end
      check("mulflush.busy", {31'd0, Stall_out}, 32'd1);
      Control = 2'b10;
      @(posedge clk); #1;
      Control = 2'b00; ALUCtrl = 5'b00000;
      #1;
      check("mulflush.idle", {31'd0, Stall_out}, 32'd0);
      check("mulflush.alu", ALUOut_out, 32'd0);
      last = zero_exp();
      run_mul("mul_after_flush", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);

      // Asynchronous reset in the middle of BUSY
      set_op(5'b00111, 1'b0, 32'd6, 32'd7, 1'b0, 5'd0, 1'b0, 32'd0);
      repeat (6) begin @(posedge clk); #1; end
      #2 reset = 1'b0;
      #1;
      check("mulrst.alu", ALUOut_out, 32'd0);
      check("mulrst.stall", {31'd0, Stall_out}, 32'd0);
      ALUCtrl = 5'b00000;
      #1 reset = 1'b1;
      #1;
      check("mulrst.idle", {31'd0, Stall_out}, 32'd0);
      last = zero_exp();
      run_mul("mul_after_rst", 32'd6, 32'd7, 32'd42);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
